// File: rtl/pipe_negator_pkg.sv
// Shared definitions for the chunked pipelined negator: operand mode encodings.
package pipe_negator_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

endpackage

// File: rtl/neg_chunk.sv
// One pipeline slice: conditionally inverts a CHUNK-bit slice and adds the incoming carry.
module neg_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             inv,
    input  logic             carry_in,
    output logic [CHUNK-1:0] result,
    output logic             carry_out
);

    logic [CHUNK-1:0] operand;

    assign operand = inv ? ~chunk : chunk;

    // Carry-out of this slice becomes the carry-in of the next, one register later.
    assign {carry_out, result} = {1'b0, operand} + {{CHUNK{1'b0}}, carry_in};

endmodule

// File: rtl/pipe_negator.sv
// Pipelined PASS / NEG / ABS unit: two's-complement negation resolved CHUNK bits
// per stage, with a global stall and a valid bit travelling with each operand.
module pipe_negator
    import pipe_negator_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    // True for the one value whose negation is not representable.
    function automatic logic is_most_negative(input logic [WIDTH-1:0] v);
        return v == {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    // Invert decision taken once at entry; later stages only follow the flag.
    function automatic logic invert_decision(input mode_t m, input logic msb);
        logic inv;
        case (m)
            MODE_NEG: inv = 1'b1;
            MODE_ABS: inv = msb;
            default:  inv = 1'b0;
        endcase
        return inv;
    endfunction

    // Stage registers: slot k holds chunks 0..k resolved, upper chunks still raw.
    logic             vld_p   [STAGES];
    logic             inv_p   [STAGES];
    logic             carry_p [STAGES];
    logic             ovf_p   [STAGES];
    logic [WIDTH-1:0] data_p  [STAGES];

    // Inputs seen by each stage's slice and the values it will register.
    logic             src_vld   [STAGES];
    logic             src_inv   [STAGES];
    logic             src_carry [STAGES];
    logic             src_ovf   [STAGES];
    logic [WIDTH-1:0] src_data  [STAGES];
    logic [CHUNK-1:0] chunk_res [STAGES];
    logic             carry_nxt [STAGES];
    logic [WIDTH-1:0] data_nxt  [STAGES];

    logic in_inv;
    logic stall;

    assign in_inv    = invert_decision(mode_t'(in_mode), in_data[WIDTH-1]);
    assign stall     = vld_p[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_p[STAGES-1];
    assign out_data  = data_p[STAGES-1];
    assign out_ovf   = ovf_p[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Stage 0 boundary: operand enters, carry-in equals the invert flag.
            assign src_vld[k]   = in_valid;
            assign src_inv[k]   = in_inv;
            assign src_carry[k] = in_inv;
            assign src_ovf[k]   = in_inv & is_most_negative(in_data);
            assign src_data[k]  = in_data;
        end else begin : g_next
            // Stage k boundary: consume the previous slot's registered state.
            assign src_vld[k]   = vld_p[k-1];
            assign src_inv[k]   = inv_p[k-1];
            assign src_carry[k] = carry_p[k-1];
            assign src_ovf[k]   = ovf_p[k-1];
            assign src_data[k]  = data_p[k-1];
        end

        neg_chunk #(.CHUNK(CHUNK)) u_chunk (
            .chunk     (src_data[k][k*CHUNK +: CHUNK]),
            .inv       (src_inv[k]),
            .carry_in  (src_carry[k]),
            .result    (chunk_res[k]),
            .carry_out (carry_nxt[k])
        );

        assign data_nxt[k] = (src_data[k] & ~(CHUNK_MASK << (k*CHUNK)))
                           | (WIDTH'(chunk_res[k]) << (k*CHUNK));
    end

    // Pipeline advance: every slot shifts together unless the output is blocked.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k]   <= 1'b0;
                inv_p[k]   <= 1'b0;
                carry_p[k] <= 1'b0;
                ovf_p[k]   <= 1'b0;
                data_p[k]  <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k]   <= src_vld[k];
                inv_p[k]   <= src_inv[k];
                carry_p[k] <= carry_nxt[k];
                ovf_p[k]   <= src_ovf[k];
                data_p[k]  <= data_nxt[k];
            end
        end
    end

endmodule

// File: doc/pipe_negator.md
PIPE_NEGATOR -- requirements
Module: pipe_negator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 16, meaning bits resolved per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, and STAGES = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the upstream operand is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts an operand this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits, meaning the two's-complement operand.
REQ-008 The block SHALL have port in_mode, input, 2 bits, meaning 00 PASS, 01 NEG, 10 ABS, 11 reserved (treated as PASS).
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_data and out_ovf are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, meaning the result.
REQ-012 The block SHALL have port out_ovf, output, 1 bit, meaning the result is not representable (NEG/ABS of the most-negative value).

Function
REQ-013 A transfer SHALL occur on a clock edge where in_valid and in_ready are both 1; output retirement SHALL occur where out_valid and out_ready are both 1.
REQ-014 Per-operand effect: PASS gives out = in; NEG gives out = (~in)+1 mod 2^WIDTH; ABS gives NEG if in[WIDTH-1]=1, otherwise PASS.
REQ-015 The invert/pass decision SHALL be made once at stage 0 from in_mode and in_data[WIDTH-1], then carried down the pipeline as a 1-bit flag.
REQ-016 Stage k (k = 0..STAGES-1) SHALL produce chunk k of the result by adding the incoming carry to the chunk; the carry-in to stage 0 SHALL equal the invert flag; the carry-out SHALL be registered into stage k+1.
REQ-017 Unprocessed upper chunks SHALL travel registered alongside, so latency from accept to out_valid is exactly STAGES cycles (4 at defaults) with no stall.
REQ-018 Throughput SHALL be one operand per cycle when out_ready=1 continuously.
REQ-019 Flow control SHALL use a global stall: stall = out_valid & ~out_ready; when stall=1, every stage register SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-020 Each stage SHALL carry a valid bit; a cycle with no transfer SHALL inject a bubble (valid=0), and bubbles SHALL NOT be squeezed out.
REQ-021 out_ovf SHALL be 1 iff the invert flag was set and the operand equalled 1 followed by WIDTH-1 zeros; out_data in that case SHALL be that same value.
REQ-022 out_data and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 in_data and in_mode SHALL be ignored when no transfer occurs.

Reset
REQ-024 While clr_n=0, all stage valid bits, out_valid, out_data, out_ovf and the carry/flag registers SHALL be 0 immediately, without a clock edge.
REQ-025 Operands in flight when reset is asserted SHALL be discarded, and none SHALL emerge after release.
REQ-026 in_ready SHALL be 1 during and after reset, since the pipe is empty.

Structure
REQ-027 Package pipe_negator_pkg SHALL hold the mode encodings MODE_PASS, MODE_NEG and MODE_ABS and the 2-bit mode typedef.
REQ-028 One sub-module, neg_chunk, SHALL implement a single stage: CHUNK-bit conditional invert, carry add, and carry-out.
REQ-029 pipe_negator SHALL instantiate STAGES copies of neg_chunk via generate and SHALL own all pipeline registers and control logic.

Verification
REQ-030 With WIDTH=64 and CHUNK=16, NEG of 0x0000000000000005 accepted at cycle 0 SHALL give out_valid at cycle 4 with out_data 0xFFFFFFFFFFFFFFFB and out_ovf=0.
REQ-031 NEG of 0x0000000000000000 SHALL give 0 with out_ovf=0, the full carry chain through all 4 stages; ABS of 0x8000000000000000 SHALL give 0x8000000000000000 with out_ovf=1.
REQ-032 ABS of 0xFFFFFFFFFFFFFFFF SHALL give 1; ABS of 0x7FFFFFFFFFFFFFFF SHALL give the same value; PASS and mode 11 of 0xDEADBEEF00000000 SHALL give the input unchanged.
REQ-033 With 8 back-to-back operands and out_ready held low from cycle 5 to cycle 9: in_ready SHALL be 0 during the stall, the held output SHALL be stable, and all 8 results SHALL emerge in order with none lost or duplicated.
REQ-034 With clr_n pulsed low at cycle 2 while 2 operands are in flight: outputs SHALL be 0 immediately, no stale result SHALL appear, and the next operand SHALL have 4-cycle latency.
REQ-035 A random self-check of 10^5 operands, with random mode and random out_ready, SHALL match the reference model (-x, |x|) for WIDTH=64/CHUNK=16 and for WIDTH=32/CHUNK=8.
